// File: rtl/cal_y_digit_entry_pkg.sv
// Shared calendar-entry constants: FSM state encodings and BCD/year limits.
package cal_y_digit_entry_pkg;

    typedef enum logic {
        S_TENS = 1'b0,
        S_ONES = 1'b1
    } entry_state_e;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [6:0] YEAR_MAX = 7'd99;

    function automatic logic is_bcd(input logic [3:0] d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/cal_bcd2bin.sv
// Two-digit BCD to binary: bin = tens*10 + ones, shared by year/month/day entry.
module cal_bcd2bin (
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    output logic [6:0] bin
);

    logic [6:0] tens_w;

    // tens*10 as tens*8 + tens*2; inputs are pre-validated so 7 bits never overflow
    assign tens_w = {3'b000, tens};
    assign bin    = (tens_w << 3) + (tens_w << 1) + {3'b000, ones};

endmodule

// File: rtl/cal_y_digit_entry.sv
// Two-digit year entry FSM: tens strobe then ones strobe, committed as a binary year.
// Optional partial-entry timeout enabled by defining CAL_Y_ENTRY_TIMEOUT_EN.
module cal_y_digit_entry
    import cal_y_digit_entry_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000000,
    parameter int unsigned CNT_W          = 26
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic [3:0] DIGIT_IN,
    input  logic       DIGIT_STB,
    input  logic       CLEAR,
    output logic [6:0] NUMBER,
    output logic       NUM_VALID,
    output logic       ERR,
    output logic       BUSY,
    output logic [3:0] TENS_DISP,
    output logic [3:0] ONES_DISP
);

    entry_state_e state_q, state_d;
    logic [6:0]   number_q, number_d;
    logic         num_valid_q, num_valid_d;
    logic         err_q, err_d;
    logic         busy_q, busy_d;
    logic [3:0]   tens_q, tens_d;
    logic [3:0]   ones_q, ones_d;
    logic [6:0]   year_bin;
    logic         digit_ok;

`ifdef CAL_Y_ENTRY_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    cal_bcd2bin u_bcd2bin (
        .tens (tens_q),
        .ones (DIGIT_IN),
        .bin  (year_bin)
    );

    assign digit_ok = is_bcd(DIGIT_IN);

    always_comb begin
        state_d     = state_q;
        number_d    = number_q;
        num_valid_d = 1'b0;
        err_d       = 1'b0;
        busy_d      = busy_q;
        tens_d      = tens_q;
        ones_d      = ones_q;
`ifdef CAL_Y_ENTRY_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        if (CLEAR) begin
            state_d = S_TENS;
            busy_d  = 1'b0;
            tens_d  = 4'd0;
`ifdef CAL_Y_ENTRY_TIMEOUT_EN
            cnt_d   = '0;
`endif
        end else begin
            unique case (state_q)
                S_TENS: begin
`ifdef CAL_Y_ENTRY_TIMEOUT_EN
                    cnt_d = '0;
`endif
                    if (DIGIT_STB) begin
                        if (digit_ok) begin
                            tens_d  = DIGIT_IN;
                            busy_d  = 1'b1;
                            state_d = S_ONES;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                S_ONES: begin
                    if (DIGIT_STB) begin
`ifdef CAL_Y_ENTRY_TIMEOUT_EN
                        cnt_d = '0;
`endif
                        if (digit_ok) begin
                            number_d    = year_bin;
                            ones_d      = DIGIT_IN;
                            num_valid_d = 1'b1;
                            busy_d      = 1'b0;
                            state_d     = S_TENS;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
`ifdef CAL_Y_ENTRY_TIMEOUT_EN
                    else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state_d = S_TENS;
                        busy_d  = 1'b0;
                        tens_d  = 4'd0;
                        err_d   = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end
                default: state_d = S_TENS;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q     <= S_TENS;
            number_q    <= 7'd0;
            num_valid_q <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            tens_q      <= 4'd0;
            ones_q      <= 4'd0;
`ifdef CAL_Y_ENTRY_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            number_q    <= number_d;
            num_valid_q <= num_valid_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            tens_q      <= tens_d;
            ones_q      <= ones_d;
`ifdef CAL_Y_ENTRY_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign NUMBER    = number_q;
    assign NUM_VALID = num_valid_q;
    assign ERR       = err_q;
    assign BUSY      = busy_q;
    assign TENS_DISP = tens_q;
    assign ONES_DISP = ones_q;

endmodule

// File: tb/tb_cal_y_digit_entry.sv
// Directed self-checking bench for cal_y_digit_entry (timeout checks under CAL_Y_ENTRY_TIMEOUT_EN).
module tb_cal_y_digit_entry;

    logic       CLK = 1'b0;
    logic       RESETN;
    logic [3:0] DIGIT_IN;
    logic       DIGIT_STB;
    logic       CLEAR;
    logic [6:0] NUMBER;
    logic       NUM_VALID;
    logic       ERR;
    logic       BUSY;
    logic [3:0] TENS_DISP;
    logic [3:0] ONES_DISP;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    cal_y_digit_entry #(
        .TIMEOUT_CYCLES (10),
        .CNT_W          (4)
    ) dut (
        .CLK       (CLK),
        .RESETN    (RESETN),
        .DIGIT_IN  (DIGIT_IN),
        .DIGIT_STB (DIGIT_STB),
        .CLEAR     (CLEAR),
        .NUMBER    (NUMBER),
        .NUM_VALID (NUM_VALID),
        .ERR       (ERR),
        .BUSY      (BUSY),
        .TENS_DISP (TENS_DISP),
        .ONES_DISP (ONES_DISP)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply inputs at the falling edge, return 1 time unit after the rising edge.
    task automatic cycle(input logic stb, input logic [3:0] d, input logic clr);
        @(negedge CLK);
        DIGIT_STB = stb;
        DIGIT_IN  = d;
        CLEAR     = clr;
        @(posedge CLK);
        #1;
    endtask

    // Idle n cycles, returning whether ERR or NUM_VALID pulsed at any point.
    task automatic idle(input int n, output logic err_seen, output logic nv_seen);
        err_seen = 1'b0;
        nv_seen  = 1'b0;
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 4'd0, 1'b0);
            err_seen = err_seen | ERR;
            nv_seen  = nv_seen | NUM_VALID;
        end
    endtask

    logic e_seen, v_seen;

    initial begin
        RESETN    = 1'b0;
        DIGIT_STB = 1'b0;
        DIGIT_IN  = 4'd0;
        CLEAR     = 1'b0;
        for (int i = 0; i < 2; i++) cycle(1'b1, 4'($urandom_range(0, 15)), 1'b0);
        check("rst_number", NUMBER, 0);
        check("rst_valid", NUM_VALID, 0);
        check("rst_err", ERR, 0);
        check("rst_busy", BUSY, 0);
        check("rst_tens", TENS_DISP, 0);
        check("rst_ones", ONES_DISP, 0);
        RESETN = 1'b1;

        // 2 then 4 -> 24
        cycle(1'b1, 4'd2, 1'b0);
        check("t2_busy", BUSY, 1);
        check("t2_tens", TENS_DISP, 2);
        check("t2_nv", NUM_VALID, 0);
        check("t2_number", NUMBER, 0);
        cycle(1'b1, 4'd4, 1'b0);
        check("c24_number", NUMBER, 24);
        check("c24_nv", NUM_VALID, 1);
        check("c24_ones", ONES_DISP, 4);
        check("c24_tens", TENS_DISP, 2);
        check("c24_busy", BUSY, 0);
        cycle(1'b0, 4'd0, 1'b0);
        check("c24_nv_drop", NUM_VALID, 0);
        check("c24_hold", NUMBER, 24);

        // Back-to-back 9,9,0,0
        cycle(1'b1, 4'd9, 1'b0);
        cycle(1'b1, 4'd9, 1'b0);
        check("c99_number", NUMBER, 99);
        check("c99_nv", NUM_VALID, 1);
        cycle(1'b1, 4'd0, 1'b0);
        check("t0_nv", NUM_VALID, 0);
        check("t0_busy", BUSY, 1);
        check("t0_number", NUMBER, 99);
        cycle(1'b1, 4'd0, 1'b0);
        check("c00_number", NUMBER, 0);
        check("c00_nv", NUM_VALID, 1);

        // Invalid tens, valid tens, invalid ones, valid ones
        cycle(1'b1, 4'd12, 1'b0);
        check("e12_err", ERR, 1);
        check("e12_busy", BUSY, 0);
        check("e12_tens", TENS_DISP, 0);
        cycle(1'b1, 4'd3, 1'b0);
        check("t3_err", ERR, 0);
        check("t3_busy", BUSY, 1);
        cycle(1'b1, 4'd15, 1'b0);
        check("e15_err", ERR, 1);
        check("e15_busy", BUSY, 1);
        check("e15_tens", TENS_DISP, 3);
        check("e15_nv", NUM_VALID, 0);
        cycle(1'b1, 4'd7, 1'b0);
        check("c37_number", NUMBER, 37);
        check("c37_nv", NUM_VALID, 1);
        check("c37_err", ERR, 0);

        // CLEAR beats a same-cycle strobe
        cycle(1'b1, 4'd5, 1'b0);
        check("t5_busy", BUSY, 1);
        cycle(1'b1, 4'd8, 1'b1);
        check("clr_busy", BUSY, 0);
        check("clr_tens", TENS_DISP, 0);
        check("clr_nv", NUM_VALID, 0);
        check("clr_err", ERR, 0);
        check("clr_number", NUMBER, 37);
        check("clr_ones", ONES_DISP, 7);
        cycle(1'b1, 4'd0, 1'b0);
        cycle(1'b1, 4'd1, 1'b0);
        check("c01_number", NUMBER, 1);
        check("c01_nv", NUM_VALID, 1);

`ifdef CAL_Y_ENTRY_TIMEOUT_EN
        // Tens 6 then 10 idle cycles: abort on the tenth
        cycle(1'b1, 4'd6, 1'b0);
        idle(9, e_seen, v_seen);
        check("to_pre_err", e_seen, 0);
        check("to_pre_busy", BUSY, 1);
        cycle(1'b0, 4'd0, 1'b0);
        check("to_err", ERR, 1);
        check("to_busy", BUSY, 0);
        check("to_tens", TENS_DISP, 0);
        check("to_nv", NUM_VALID | v_seen, 0);
        check("to_number", NUMBER, 1);
        // Ones strobe lands in the timeout cycle and commits
        cycle(1'b1, 4'd6, 1'b0);
        idle(9, e_seen, v_seen);
        cycle(1'b1, 4'd3, 1'b0);
        check("to_win_number", NUMBER, 63);
        check("to_win_nv", NUM_VALID, 1);
        check("to_win_err", ERR | e_seen, 0);
`else
        // Without timeout the partial entry waits indefinitely
        cycle(1'b1, 4'd6, 1'b0);
        idle(12, e_seen, v_seen);
        check("wait_err", e_seen, 0);
        check("wait_busy", BUSY, 1);
        check("wait_tens", TENS_DISP, 6);
        cycle(1'b1, 4'd3, 1'b0);
        check("wait_number", NUMBER, 63);
        check("wait_nv", NUM_VALID, 1);
`endif

        // Strobe held two cycles counts as two digits
        cycle(1'b1, 4'd4, 1'b0);
        cycle(1'b1, 4'd4, 1'b0);
        check("held_number", NUMBER, 44);
        check("held_nv", NUM_VALID, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cal_y_digit_entry.md
Name: cal_y_digit_entry

Overview:
- Assembles a two-digit calendar year (00-99) from sequential BCD digit strobes (keypad or set-button logic): tens digit first, then ones digit.
- Produces a registered 7-bit binary year with a one-cycle commit pulse.
- Inverse of the year binary-to-tens/ones split used on the display path. Sits between the user-input debouncer and the calendar year register.

Parameters:
- TIMEOUT_CYCLES, 50000000, cycles allowed between tens and ones strobes before partial entry is discarded (timeout feature only)
- CNT_W, 26, width of timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
- CLK  input  1  system clock, all logic on rising edge
- RESETN  input  1  synchronous active-low reset
- DIGIT_IN  input  4  BCD digit, sampled only when DIGIT_STB=1
- DIGIT_STB  input  1  single-cycle digit-valid strobe
- CLEAR  input  1  abandon partial entry, return to tens state
- NUMBER  output  7  committed binary year 0-99, held between commits
- NUM_VALID  output  1  one-cycle pulse when NUMBER updated
- ERR  output  1  one-cycle pulse on rejected digit (>9) or timeout abort
- BUSY  output  1  high while tens digit held, awaiting ones
- TENS_DISP  output  4  tens digit entered so far (echo for display)
- ONES_DISP  output  4  ones digit of last commit (echo for display)

Behaviour:
- Reset (RESETN=0 at edge): state=S_TENS; NUMBER=0, NUM_VALID=0, ERR=0, BUSY=0, TENS_DISP=0, ONES_DISP=0, counter=0. Reset overrides all inputs.
- All outputs are registered. NUM_VALID and ERR default to 0 every cycle unless set.
- S_TENS, DIGIT_STB=1:
  - DIGIT_IN<=9: TENS_DISP<=DIGIT_IN, BUSY<=1, counter<=0, go to S_ONES.
  - DIGIT_IN>9: ERR<=1, remain in S_TENS, TENS_DISP unchanged.
- S_ONES, DIGIT_STB=1:
  - DIGIT_IN<=9: NUMBER<=TENS_DISP*10+DIGIT_IN, ONES_DISP<=DIGIT_IN, NUM_VALID<=1, BUSY<=0, go to S_TENS.
  - DIGIT_IN>9: ERR<=1, remain in S_ONES, tens digit retained, counter<=0.
- Latency: NUMBER and NUM_VALID visible the cycle after the edge that samples the ones strobe.
- Arithmetic: tens*10 computed as (t<<3)+(t<<1) in 7 bits. Max 99; no overflow possible because digits are validated.
- CLEAR=1 (any state): go to S_TENS, BUSY<=0, TENS_DISP<=0. NUMBER and ONES_DISP unchanged, no ERR. CLEAR beats DIGIT_STB in the same cycle.
- Back-to-back strobes on consecutive cycles are accepted. Each strobe is one digit; a strobe held high for N cycles counts as N digits.
- NUMBER never shows a partial value; it changes only on commit.

Optional Feature:
- Macro CAL_Y_ENTRY_TIMEOUT_EN.
- Defined:
  - In S_ONES the counter increments each cycle without a strobe.
  - When counter==TIMEOUT_CYCLES-1 and no strobe/CLEAR: go to S_TENS, BUSY<=0, TENS_DISP<=0, ERR<=1, counter<=0.
  - A valid strobe in the timeout cycle wins (commit).
  - Counter held at 0 in S_TENS.
- Undefined: no counter logic; S_ONES waits indefinitely; CNT_W and TIMEOUT_CYCLES unused.

Decomposition:
- Shared calendar constants include: state encodings S_TENS=1'b0, S_ONES=1'b1; BCD_MAX=4'd9; YEAR_MAX=7'd99.
- One combinational sub-module, cal_bcd2bin: inputs tens[3:0], ones[3:0]; output bin[6:0]=tens*10+ones. It is reused by month/day entry blocks.
- FSM, counter and output registers stay in cal_y_digit_entry.

Test Plan:
- Reset: RESETN=0 for 2 cycles with random strobes -> all outputs 0, BUSY=0.
- Strobe 2 then 4 -> BUSY=1 after first, then NUMBER=24, NUM_VALID one cycle, ONES_DISP=4, TENS_DISP=2.
- Strobes 9,9 then 0,0 -> NUMBER=99 then NUMBER=0, two NUM_VALID pulses.
- Strobe 12 (tens) -> ERR pulse, BUSY=0. Then 3, then 15 -> ERR pulse, still BUSY. Then 7 -> NUMBER=37.
- Strobe 5, then CLEAR and strobe 8 in the same cycle -> no commit, BUSY=0, NUMBER keeps previous value. Then 0,1 -> NUMBER=1.
- With CAL_Y_ENTRY_TIMEOUT_EN and TIMEOUT_CYCLES=10: strobe 6, idle 10 cycles -> ERR pulse, BUSY=0, no commit. Repeat with ones strobe 3 on cycle 10 -> NUMBER=63, no ERR.
